// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 box-blur stream.
package blur_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic [11:0] sum_t;

  localparam logic [12:0] DIV9_MUL   = 13'd7282;
  localparam int          DIV9_SHIFT = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // floor(s/9) for s in 0..2295 via multiply-and-shift.
  function automatic logic [7:0] div9(input sum_t s);
    logic [24:0] prod;
    prod = 25'(s) * 25'(DIV9_MUL);
    return prod[DIV9_SHIFT +: 8];
  endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// Single-clock row store: one write port, one read port, registered read data.
module blur_line_buffer #(
  parameter int depth  = 256,
  parameter int data_w = 48,
  parameter int addr_w = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [data_w-1:0] wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [data_w-1:0] rdata
);

  logic [data_w-1:0] mem [depth];

  // Write on demand, read every cycle with one clock of latency.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/box_blur_3x3_stream.sv
// Streaming 3x3 box blur over one raster-order RGB frame; border pixels pass through.
module box_blur_3x3_stream
  import blur_pkg::*;
#(
  parameter int width  = 256,
  parameter int height = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_last,
  output logic       busy
);

  // Column counter runs past width-1 during the flush (virtual columns).
  localparam int CW = $clog2(width + 2);
  localparam int RW = $clog2(height);
  localparam int AW = $clog2(width);
  localparam logic [CW-1:0] COL_LAST = CW'(width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(height - 1);

  state_t            state_r, state_s;
  logic [CW-1:0]     col_r, col_s, ocol_r;
  logic [RW-1:0]     row_r, row_s, orow_r;
  pixel_t [2:0][2:0] win_r, nwin_s;   // [column][row], row 0 is the oldest line
  pixel_t            in_px_s, lb1_s, lb2_s, center_s, blur_s;
  logic [47:0]       lb_rd_s;
  logic [AW-1:0]     rd_addr_s;
  sum_t              sum_r_s, sum_g_s, sum_b_s;
  logic              in_ready_s, acc_s, fl_adv_s, shift_s, load_s, last_xfer_s, border_s;

  assign in_px_s     = {in_r, in_g, in_b};
  assign lb2_s       = lb_rd_s[47:24];
  assign lb1_s       = lb_rd_s[23:0];
  assign in_ready_s  = (state_r != FLUSH) && (!out_valid || out_ready);
  assign in_ready    = in_ready_s;
  assign acc_s       = in_valid && in_ready_s;
  // Flush advances whenever the output slot frees, until the last pixel is loaded.
  assign fl_adv_s    = (state_r == FLUSH) && (!out_valid || (out_ready && !out_last));
  assign shift_s     = acc_s || fl_adv_s;
  assign load_s      = (acc_s && (state_r == RUN)) || fl_adv_s;
  assign last_xfer_s = out_valid && out_ready && out_last;
  // Read ahead at the column the next pixel will land on; clamp virtual columns.
  assign rd_addr_s   = (col_s >= CW'(width)) ? AW'(width - 1) : col_s[AW-1:0];

  // Both rows shift together: older line gets the previous line, newer line gets the input.
  blur_line_buffer #(
    .depth  (width),
    .data_w (48),
    .addr_w (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (acc_s),
    .waddr (col_r[AW-1:0]),
    .wdata ({lb1_s, in_px_s}),
    .raddr (rd_addr_s),
    .rdata (lb_rd_s)
  );

  // Next input position; wraps per frame, keeps counting virtual columns in flush.
  always_comb begin
    col_s = col_r;
    row_s = row_r;
    if (rst || ((state_r == FLUSH) && last_xfer_s)) begin
      col_s = '0;
      row_s = '0;
    end else if (shift_s) begin
      if (state_r == FLUSH) begin
        col_s = col_r + CW'(1);
      end else if (col_r == COL_LAST) begin
        col_s = '0;
        row_s = (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
      end else begin
        col_s = col_r + CW'(1);
      end
    end else begin
      col_s = col_r;
    end
  end

  // Frame phase: prime the window, stream, then drain the trailing outputs.
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (acc_s && (row_r == RW'(1)) && (col_r == '0)) state_s = RUN;
        else state_s = FILL;
      end
      RUN: begin
        if (acc_s && (row_r == ROW_LAST) && (col_r == COL_LAST)) state_s = FLUSH;
        else state_s = RUN;
      end
      FLUSH: begin
        if (last_xfer_s) state_s = FILL;
        else state_s = FLUSH;
      end
      default: state_s = FILL;
    endcase
  end

  // Shifted window, per-channel 9-term sums and the border pass-through select.
  always_comb begin
    nwin_s[0]    = win_r[1];
    nwin_s[1]    = win_r[2];
    nwin_s[2][0] = lb2_s;
    nwin_s[2][1] = lb1_s;
    nwin_s[2][2] = in_px_s;
    sum_r_s = '0;
    sum_g_s = '0;
    sum_b_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sum_r_s = sum_r_s + sum_t'(nwin_s[i][j].r);
        sum_g_s = sum_g_s + sum_t'(nwin_s[i][j].g);
        sum_b_s = sum_b_s + sum_t'(nwin_s[i][j].b);
      end
    end
    center_s = nwin_s[1][1];
    border_s = (orow_r == '0) || (orow_r == ROW_LAST) || (ocol_r == '0) || (ocol_r == COL_LAST);
    if (border_s) begin
      blur_s = center_s;
    end else begin
      blur_s = {div9(sum_r_s), div9(sum_g_s), div9(sum_b_s)};
    end
  end

  // Phase and input-position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Window advances with every real or virtual column.
  always_ff @(posedge clk) begin
    if (shift_s) begin
      win_r <= nwin_s;
    end
  end

  // Output register and output-position counters; data holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
      ocol_r    <= '0;
      orow_r    <= '0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      {out_r, out_g, out_b} <= blur_s;
      out_last  <= (orow_r == ROW_LAST) && (ocol_r == COL_LAST);
      if (ocol_r == COL_LAST) begin
        ocol_r <= '0;
        orow_r <= (orow_r == ROW_LAST) ? '0 : orow_r + RW'(1);
      end else begin
        ocol_r <= ocol_r + CW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Frame-in-progress flag: first accepted pixel to final output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (acc_s) begin
      busy <= 1'b1;
    end else if (last_xfer_s) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_box_blur_3x3_stream.sv
// Directed bench for box_blur_3x3_stream on a 4x4 frame with a behavioural reference.
module tb_box_blur_3x3_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r, in_g, in_b;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_r, out_g, out_b;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [23:0] img [N];
  logic [23:0] cap [N];
  logic [23:0] exp_q [$];

  int  cyc = 0;
  int  stall_lo = -100;
  int  acc_total = 0, out_total = 0, last_total = 0, stall_seen = 0;
  int  acc_base = 0, out_base = 0, last_base = 0;
  int  frame_no = 0, first_seen = 0;
  bit  mon_en = 1'b0;
  bit  hold_pending = 1'b0;
  logic [24:0] hold_val;

  always #5 clk = ~clk;

  box_blur_3x3_stream #(.width(W), .height(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: border pixels copy through, interior is floor of the 3x3 mean.
  function automatic logic [23:0] model(input int j);
    int r, c;
    int s [3];
    logic [23:0] p;
    r = j / W;
    c = j % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return img[j];
    s = '{0, 0, 0};
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        p = img[(r + dr) * W + c + dc];
        s[0] += int'(p[23:16]);
        s[1] += int'(p[15:8]);
        s[2] += int'(p[7:0]);
      end
    end
    return {8'(s[0] / 9), 8'(s[1] / 9), 8'(s[2] / 9)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = !(cyc >= stall_lo && cyc < stall_lo + 10);
  end

  // Single compare process: everything seen here happens at the following rising edge.
  always @(negedge clk) begin
    int idx;
    logic [23:0] e;
    if (mon_en && !rst) begin
      if (hold_pending)
        chk("hold_stable", 32'({out_last, out_r, out_g, out_b}), 32'(hold_val));
      if (out_valid && first_seen != frame_no) begin
        first_seen = frame_no;
        chk("first_valid_latency", 32'(acc_total - acc_base), 32'(W + 2));
      end
      if ((acc_total - acc_base) == N && last_total == last_base)
        chk("flush_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        stall_seen++;
        hold_pending = 1'b1;
        hold_val = {out_last, out_r, out_g, out_b};
      end else begin
        hold_pending = 1'b0;
      end
      if (in_valid && in_ready) acc_total++;
      if (out_valid && out_ready) begin
        idx = out_total - out_base;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: actual index %0d required no output", idx);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", 32'({out_r, out_g, out_b}), 32'(e));
          chk("out_last", 32'(out_last), 32'(idx == N - 1));
        end
        if (idx >= 0 && idx < N) cap[idx] = {out_r, out_g, out_b};
        out_total++;
        if (out_last) last_total++;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic feed(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      {in_r, in_g, in_b} = img[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: actual in_ready=0 required 1 at pixel %0d", i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame();
    int t;
    acc_base  = acc_total;
    out_base  = out_total;
    last_base = last_total;
    frame_no++;
    for (int j = 0; j < N; j++) exp_q.push_back(model(j));
    feed(N);
    t = 0;
    while (last_total == last_base && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: actual outputs=%0d required %0d", out_total - out_base, N);
    end
    @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("ready_after_frame", 32'(in_ready), 32'd1);
    chk("valid_after_frame", 32'(out_valid), 32'd0);
    chk("output_count", 32'(out_total - out_base), 32'(N));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_r = 8'd0;
    in_g = 8'd0;
    in_b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'({out_r, out_g, out_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Constant frame passes through unchanged.
    for (int j = 0; j < N; j++) img[j] = 24'h6432C8;
    run_frame();
    chk("const_pin_0", 32'(cap[0]), 32'h6432C8);
    chk("const_pin_5", 32'(cap[5]), 32'h6432C8);
    chk("const_pin_15", 32'(cap[15]), 32'h6432C8);

    // Red ramp equal to raster index.
    for (int j = 0; j < N; j++) img[j] = {8'(j), 16'h0000};
    run_frame();
    chk("ramp_pin_11", 32'(cap[5]), 32'h050000);
    chk("ramp_pin_12", 32'(cap[6]), 32'h060000);
    chk("ramp_pin_21", 32'(cap[9]), 32'h090000);
    chk("ramp_pin_22", 32'(cap[10]), 32'h0A0000);
    chk("ramp_pin_border0", 32'(cap[0]), 32'h000000);
    chk("ramp_pin_border15", 32'(cap[15]), 32'h0F0000);

    // Near-saturated frame: largest sums, no overflow.
    for (int j = 0; j < N; j++) img[j] = 24'hFFFFFF;
    img[5] = 24'hFEFEFE;
    run_frame();
    chk("sat_pin_11", 32'(cap[5]), 32'hFEFEFE);
    chk("sat_pin_12", 32'(cap[6]), 32'hFEFEFE);
    chk("sat_pin_border", 32'(cap[0]), 32'hFFFFFF);

    // Same ramp with a 10-cycle downstream stall mid-frame.
    for (int j = 0; j < N; j++) img[j] = {8'(j), 8'(2 * j), 8'(255 - j)};
    stall_lo = cyc + 12;
    s0 = stall_seen;
    run_frame();
    chk("stall_cycles", 32'(stall_seen - s0), 32'd10);
    chk("stall_pin_11", 32'(cap[5]), 32'h050AFA);
    chk("stall_pin_22", 32'(cap[10]), 32'h0A14F5);

    // Reset after 7 inputs, then a fresh constant frame.
    mon_en = 1'b0;
    feed(7);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) img[j] = 24'h0A141E;
    run_frame();
    chk("rst_frame_pin_0", 32'(cap[0]), 32'h0A141E);
    chk("rst_frame_pin_15", 32'(cap[15]), 32'h0A141E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
